act_wb_ctrl: RTL and testbench

Write-back controller that sits directly upstream of the ping-pong activation memory pair. It takes the 8-bit activation stream from the compute pipeline through a valid/ready handshake and packs four activations into each 32-bit word. It then writes the packed words into the bank selected for the current layer at consecutive addresses. It stalls whenever the target bank is being read, because the memory wrapper gives read addresses priority.

---
 rtl/act_wb_ctrl.sv | 126 ++++++++++++
 tb/tb_act_wb_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/act_wb_ctrl.sv
// act_wb_ctrl: packs 8-bit activations into 32-bit words and writes them
// to the selected ping-pong activation bank, yielding to bank reads.
module act_wb_ctrl #(
  parameter int ACTMEMADRWID = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    layer_start,
  input  logic                    wbank_sel,
  input  logic [ACTMEMADRWID-1:0] base_addr,
  input  logic [ACTMEMADRWID+2:0] layer_len,
  input  logic                    act_valid,
  input  logic [7:0]              act_data,
  output logic                    act_ready,
  input  logic                    ractmem0ena,
  input  logic                    ractmem1ena,
  output logic                    wactmem0ena,
  output logic                    wactmem1ena,
  output logic                    wactmem0wea,
  output logic                    wactmem1wea,
  output logic [ACTMEMADRWID-1:0] wactmem0addr,
  output logic [ACTMEMADRWID-1:0] wactmem1addr,
  output logic [31:0]             wactmemdata,
  output logic                    busy,
  output logic                    layer_done
);
  localparam int AW = ACTMEMADRWID;
  localparam int LW = ACTMEMADRWID + 3;
  localparam logic [AW-1:0] AONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [LW-1:0] LONE = {{(LW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e        state_q;
  logic          bank_q;
  logic          pend_q;
  logic [AW-1:0] addr_q;
  logic [LW-1:0] rem_q;
  logic [1:0]    lane_q;
  logic [31:0]   asm_q;
  logic [31:0]   data_q;

  logic          rd_conf;
  logic          wr_fire;
  logic          accept;
  logic          last;
  logic          commit;
  logic [31:0]   merged;

  // a read on the target bank wins; the other bank never stalls us
  assign rd_conf = bank_q ? ractmem1ena : ractmem0ena;
  assign wr_fire = pend_q && !rd_conf;
  assign act_ready = (state_q == RUN) && (!pend_q || wr_fire);
  assign accept = act_valid && act_ready;
  assign last = (rem_q == LONE);
  assign commit = accept && ((lane_q == 2'd3) || last);
  assign merged = asm_q | ({24'd0, act_data} << {lane_q, 3'b000});

  assign wactmem0ena = wr_fire && !bank_q;
  assign wactmem1ena = wr_fire && bank_q;
  assign wactmem0wea = wactmem0ena;
  assign wactmem1wea = wactmem1ena;
  assign wactmem0addr = addr_q;
  assign wactmem1addr = addr_q;
  assign wactmemdata = data_q;
  assign busy = (state_q != IDLE);
  assign layer_done = (state_q == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bank_q  <= 1'b0;
      pend_q  <= 1'b0;
      addr_q  <= '0;
      rem_q   <= '0;
      lane_q  <= '0;
      asm_q   <= '0;
      data_q  <= '0;
    end else begin
      if (wr_fire) begin
        addr_q <= addr_q + AONE;
      end
      if (commit) begin
        pend_q <= 1'b1;
        data_q <= merged;
      end else if (wr_fire) begin
        pend_q <= 1'b0;
      end
      if (accept) begin
        rem_q <= rem_q - LONE;
        if (commit) begin
          lane_q <= '0;
          asm_q  <= '0;
        end else begin
          lane_q <= lane_q + 2'd1;
          asm_q  <= merged;
        end
      end
      unique case (state_q)
        IDLE: begin
          if (layer_start) begin
            bank_q  <= wbank_sel;
            addr_q  <= base_addr;
            rem_q   <= layer_len;
            lane_q  <= '0;
            asm_q   <= '0;
            state_q <= (layer_len == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (accept && last) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (wr_fire) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_act_wb_ctrl.sv
// tb_act_wb_ctrl: directed checks of packing, wrap, read stalls,
// zero-length layers, reset recovery and ignored restarts.
module tb_act_wb_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        layer_start;
  logic        wbank_sel;
  logic [9:0]  base_addr;
  logic [12:0] layer_len;
  logic        act_valid;
  logic [7:0]  act_data;
  logic        act_ready;
  logic        ractmem0ena;
  logic        ractmem1ena;
  logic        wactmem0ena;
  logic        wactmem1ena;
  logic        wactmem0wea;
  logic        wactmem1wea;
  logic [9:0]  wactmem0addr;
  logic [9:0]  wactmem1addr;
  logic [31:0] wactmemdata;
  logic        busy;
  logic        layer_done;

  act_wb_ctrl #(.ACTMEMADRWID(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .layer_start(layer_start), .wbank_sel(wbank_sel),
    .base_addr(base_addr), .layer_len(layer_len),
    .act_valid(act_valid), .act_data(act_data), .act_ready(act_ready),
    .ractmem0ena(ractmem0ena), .ractmem1ena(ractmem1ena),
    .wactmem0ena(wactmem0ena), .wactmem1ena(wactmem1ena),
    .wactmem0wea(wactmem0wea), .wactmem1wea(wactmem1wea),
    .wactmem0addr(wactmem0addr), .wactmem1addr(wactmem1addr),
    .wactmemdata(wactmemdata),
    .busy(busy), .layer_done(layer_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wea_err = 0;
  int wb[$];
  int wa[$];
  int wc[$];
  logic [31:0] wd[$];

  always @(posedge clk) cyc++;

  // write monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (wactmem0ena) begin
      wb.push_back(0); wa.push_back(int'(wactmem0addr));
      wd.push_back(wactmemdata); wc.push_back(cyc);
    end
    if (wactmem1ena) begin
      wb.push_back(1); wa.push_back(int'(wactmem1addr));
      wd.push_back(wactmemdata); wc.push_back(cyc);
    end
    if (wactmem0wea !== wactmem0ena || wactmem1wea !== wactmem1ena)
      wea_err++;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic clr_log();
    wb.delete(); wa.delete(); wd.delete(); wc.delete();
  endtask

  task automatic begin_layer(input logic bank, input logic [9:0] base,
                             input logic [12:0] len);
    @(posedge clk); #1;
    layer_start = 1'b1; wbank_sel = bank;
    base_addr = base; layer_len = len;
    @(posedge clk); #1;
    layer_start = 1'b0;
  endtask

  task automatic stream(input int n, input logic [7:0] first,
                        output int stalls);
    int i = 0;
    int guard = 0;
    stalls = 0;
    while (i < n && guard < 200) begin
      act_valid = 1'b1;
      act_data = first + 8'(i);
      @(negedge clk);
      if (act_ready) i++;
      else stalls++;
      @(posedge clk); #1;
      guard++;
    end
    act_valid = 1'b0;
    check("stream_budget", 32'(i), 32'(n));
  endtask

  task automatic wait_done(output int dcyc);
    dcyc = -1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (layer_done) begin
        dcyc = cyc;
        break;
      end
    end
    check("layer_done_seen", 32'(layer_done), 32'd1);
  endtask

  int st;
  int dc;
  int cyc_free;

  initial begin
    rst_n = 1'b0; layer_start = 1'b0; wbank_sel = 1'b0;
    base_addr = '0; layer_len = '0; act_valid = 1'b0; act_data = '0;
    ractmem0ena = 1'b0; ractmem1ena = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ctrl", {25'd0, act_ready, busy, layer_done, wactmem0ena,
          wactmem1ena, wactmem0wea, wactmem1wea}, 32'd0);
    check("rst_addr", {12'd0, wactmem0addr, wactmem1addr}, 32'd0);
    check("rst_data", wactmemdata, 32'd0);
    rst_n = 1'b1;

    // basic pack, bank 0
    clr_log();
    begin_layer(1'b0, 10'h000, 13'd8);
    stream(8, 8'h01, st);
    check("t1_stalls", 32'(st), 32'd0);
    wait_done(dc);
    check("t1_nwr", 32'(wb.size()), 32'd2);
    check("t1_bank", 32'(wb[0] + wb[1]), 32'd0);
    check("t1_a0", 32'(wa[0]), 32'h000);
    check("t1_d0", wd[0], 32'h04030201);
    check("t1_a1", 32'(wa[1]), 32'h001);
    check("t1_d1", wd[1], 32'h08070605);
    check("t1_done_lat", 32'(dc - wc[1]), 32'd1);
    @(negedge clk);
    check("t1_idle", {30'd0, busy, layer_done}, 32'd0);

    // partial word and address wrap, bank 1
    clr_log();
    begin_layer(1'b1, 10'h3FF, 13'd9);
    stream(9, 8'h01, st);
    wait_done(dc);
    check("t2_nwr", 32'(wb.size()), 32'd3);
    check("t2_bank", 32'(wb[0] + wb[1] + wb[2]), 32'd3);
    check("t2_a0", 32'(wa[0]), 32'h3FF);
    check("t2_d0", wd[0], 32'h04030201);
    check("t2_a1", 32'(wa[1]), 32'h000);
    check("t2_d1", wd[1], 32'h08070605);
    check("t2_a2", 32'(wa[2]), 32'h001);
    check("t2_d2", wd[2], 32'h00000009);

    // read conflict on bank 1; bank 0 reads must not stall
    clr_log();
    ractmem0ena = 1'b1;
    begin_layer(1'b1, 10'h010, 13'd8);
    stream(4, 8'h11, st);
    check("t3_no_stall_r0", 32'(st), 32'd0);
    ractmem1ena = 1'b1;
    act_valid = 1'b1; act_data = 8'h15;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t3_hold_ena", 32'(wactmem1ena), 32'd0);
      check("t3_hold_rdy", 32'(act_ready), 32'd0);
      check("t3_hold_addr", 32'(wactmem1addr), 32'h010);
      check("t3_hold_data", wactmemdata, 32'h14131211);
      @(posedge clk); #1;
    end
    ractmem1ena = 1'b0;
    cyc_free = cyc;
    stream(4, 8'h15, st);
    wait_done(dc);
    ractmem0ena = 1'b0;
    check("t3_nwr", 32'(wb.size()), 32'd2);
    check("t3_fire_cyc", 32'(wc[0]), 32'(cyc_free));
    check("t3_a0", 32'(wa[0]), 32'h010);
    check("t3_d0", wd[0], 32'h14131211);
    check("t3_a1", 32'(wa[1]), 32'h011);
    check("t3_d1", wd[1], 32'h18171615);
    check("t3_bank", 32'(wb[0] + wb[1]), 32'd2);

    // zero-length layer
    clr_log();
    begin_layer(1'b0, 10'h005, 13'd0);
    @(negedge clk);
    check("t4_busy", 32'(busy), 32'd1);
    check("t4_done", 32'(layer_done), 32'd1);
    @(negedge clk);
    check("t4_idle", {30'd0, busy, layer_done}, 32'd0);
    check("t4_nwr", 32'(wb.size()), 32'd0);

    // reset mid-layer
    clr_log();
    @(posedge clk); #1;
    begin_layer(1'b0, 10'h020, 13'd12);
    stream(6, 8'h31, st);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("t5_ctrl", {25'd0, act_ready, busy, layer_done, wactmem0ena,
          wactmem1ena, wactmem0wea, wactmem1wea}, 32'd0);
    check("t5_addr", {12'd0, wactmem0addr, wactmem1addr}, 32'd0);
    check("t5_data", wactmemdata, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("t5_nwr", 32'(wb.size()), 32'd1);
    check("t5_a0", 32'(wa[0]), 32'h020);
    check("t5_d0", wd[0], 32'h34333231);
    clr_log();
    begin_layer(1'b0, 10'h040, 13'd4);
    stream(4, 8'hA1, st);
    wait_done(dc);
    check("t5_new_nwr", 32'(wb.size()), 32'd1);
    check("t5_new_a", 32'(wa[0]), 32'h040);
    check("t5_new_d", wd[0], 32'hA4A3A2A1);

    // layer_start while running is ignored
    clr_log();
    begin_layer(1'b1, 10'h100, 13'd8);
    stream(3, 8'h61, st);
    layer_start = 1'b1; wbank_sel = 1'b0;
    base_addr = 10'h200; layer_len = 13'd4;
    @(posedge clk); #1;
    layer_start = 1'b0;
    stream(5, 8'h64, st);
    wait_done(dc);
    check("t6_nwr", 32'(wb.size()), 32'd2);
    check("t6_bank", 32'(wb[0] + wb[1]), 32'd2);
    check("t6_a0", 32'(wa[0]), 32'h100);
    check("t6_d0", wd[0], 32'h64636261);
    check("t6_a1", 32'(wa[1]), 32'h101);
    check("t6_d1", wd[1], 32'h68676665);

    repeat (3) @(posedge clk);
    check("wea_eq_ena", 32'(wea_err), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
